// File: rtl/gpio_irq_ctrl.sv
// rtl/gpio_irq_ctrl.sv - GPIO edge/level interrupt controller with strobe/ack register port
// Optional LEVEL register (0x14) and level-sensitive pins enabled by GPIO_IRQ_LEVEL_EN.
module gpio_irq_ctrl #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rstz,
    input  logic [N-1:0] gpio_read,
    input  logic [4:0]   bus_addr,
    input  logic [31:0]  bus_wdata,
    input  logic         bus_we,
    input  logic         bus_stb,
    output logic [31:0]  bus_rdata,
    output logic         bus_ack,
    output logic         irq
);

    localparam logic [2:0] W_DATA    = 3'd0;
    localparam logic [2:0] W_RISE_EN = 3'd1;
    localparam logic [2:0] W_FALL_EN = 3'd2;
    localparam logic [2:0] W_PENDING = 3'd3;
    localparam logic [2:0] W_MASK    = 3'd4;
    localparam logic [2:0] W_LEVEL   = 3'd5;

    logic [N-1:0] rise_en;
    logic [N-1:0] fall_en;
    logic [N-1:0] pending;
    logic [N-1:0] mask;
    logic [N-1:0] prev;
    logic [N-1:0] rise;
    logic [N-1:0] fall;
    logic [N-1:0] set_bits;
    logic [N-1:0] clr_bits;
    logic         armed;
    logic         accept;
    logic         wr;
    logic [2:0]   word;
    logic [31:0]  rd_mux;

    // Byte-lane bits and write data above N are deliberately ignored.
    logic unused_bits;
    assign unused_bits = ^{bus_addr[1:0], bus_wdata};

    function automatic logic [31:0] zext(input logic [N-1:0] v);
        logic [31:0] r;
        r = '0;
        r[N-1:0] = v;
        return r;
    endfunction

    assign accept = bus_stb & ~bus_ack;
    assign wr     = accept & bus_we;
    assign word   = bus_addr[4:2];

    // armed masks the first cycle after reset, when prev is not yet a real sample.
    assign rise = {N{armed}} & gpio_read & ~prev;
    assign fall = {N{armed}} & ~gpio_read & prev;

`ifdef GPIO_IRQ_LEVEL_EN
    logic [N-1:0] level;

    assign set_bits = (~level & ((rise & rise_en) | (fall & fall_en)))
                    | (level & {N{armed}} & gpio_read & rise_en);
`else
    assign set_bits = (rise & rise_en) | (fall & fall_en);
`endif

    assign clr_bits = (wr && word == W_PENDING) ? bus_wdata[N-1:0] : '0;

    always_comb begin
        rd_mux = '0;
        case (word)
            W_DATA:    rd_mux = zext(gpio_read);
            W_RISE_EN: rd_mux = zext(rise_en);
            W_FALL_EN: rd_mux = zext(fall_en);
            W_PENDING: rd_mux = zext(pending);
            W_MASK:    rd_mux = zext(mask);
`ifdef GPIO_IRQ_LEVEL_EN
            W_LEVEL:   rd_mux = zext(level);
`endif
            default:   rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            prev    <= '0;
            armed   <= 1'b0;
            pending <= '0;
            irq     <= 1'b0;
        end else begin
            prev    <= gpio_read;
            armed   <= 1'b1;
            // Set is ORed in after the clear so a same-cycle edge survives W1C.
            pending <= (pending & ~clr_bits) | set_bits;
            irq     <= |(pending & ~mask);
        end
    end

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            rise_en   <= '0;
            fall_en   <= '0;
            mask      <= '1;
            bus_ack   <= 1'b0;
            bus_rdata <= '0;
        end else begin
            bus_ack <= accept;
            if (accept && !bus_we) begin
                bus_rdata <= rd_mux;
            end
            if (wr) begin
                case (word)
                    W_RISE_EN: rise_en <= bus_wdata[N-1:0];
                    W_FALL_EN: fall_en <= bus_wdata[N-1:0];
                    W_MASK:    mask    <= bus_wdata[N-1:0];
                    default:   ;
                endcase
            end
        end
    end

`ifdef GPIO_IRQ_LEVEL_EN
    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            level <= '0;
        end else if (wr && word == W_LEVEL) begin
            level <= bus_wdata[N-1:0];
        end
    end
`endif

endmodule

// File: tb/tb_gpio_irq_ctrl.sv
// tb/tb_gpio_irq_ctrl.sv - self-checking bench for gpio_irq_ctrl with behavioural register model
module tb_gpio_irq_ctrl;

    localparam int N = 16;

    logic         clk = 1'b0;
    logic         rstz;
    logic [N-1:0] gpio_read;
    logic [4:0]   bus_addr;
    logic [31:0]  bus_wdata;
    logic         bus_we;
    logic         bus_stb;
    logic [31:0]  bus_rdata;
    logic         bus_ack;
    logic         irq;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    gpio_irq_ctrl #(.N(N)) dut (
        .clk       (clk),
        .rstz      (rstz),
        .gpio_read (gpio_read),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_we    (bus_we),
        .bus_stb   (bus_stb),
        .bus_rdata (bus_rdata),
        .bus_ack   (bus_ack),
        .irq       (irq)
    );

    // Reference model: register file plus per-pin event rules.
    logic [N-1:0] m_prev, m_rise, m_fall, m_pend, m_mask, m_level;
    bit           m_armed, m_ack, m_irq;
    logic [31:0]  m_rdata;

    task automatic model_reset();
        m_prev = '0; m_rise = '0; m_fall = '0; m_pend = '0;
        m_mask = '1; m_level = '0;
        m_armed = 0; m_ack = 0; m_irq = 0; m_rdata = '0;
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] a);
        logic [31:0] v;
        v = 0;
        case (int'(a) / 4)
            0: v = 32'(gpio_read);
            1: v = 32'(m_rise);
            2: v = 32'(m_fall);
            3: v = 32'(m_pend);
            4: v = 32'(m_mask);
`ifdef GPIO_IRQ_LEVEL_EN
            5: v = 32'(m_level);
`endif
            default: v = 0;
        endcase
        return v;
    endfunction

    task automatic model_edge();
        bit           acc, any;
        logic [N-1:0] setv, clr;
        int           reg_idx;
        acc     = bus_stb && !m_ack;
        reg_idx = int'(bus_addr) / 4;
        setv    = '0;
        for (int i = 0; i < N; i++) begin
            bit went_up, went_down;
            went_up   = m_armed && gpio_read[i] && !m_prev[i];
            went_down = m_armed && !gpio_read[i] && m_prev[i];
            if (m_level[i])
                setv[i] = m_armed && gpio_read[i] && m_rise[i];
            else
                setv[i] = (went_up && m_rise[i]) || (went_down && m_fall[i]);
        end
        clr = (acc && bus_we && reg_idx == 3) ? bus_wdata[N-1:0] : '0;
        any = 0;
        for (int i = 0; i < N; i++)
            if (m_pend[i] && !m_mask[i]) any = 1;
        if (acc && !bus_we) m_rdata = model_read(bus_addr);
        m_pend = (m_pend & ~clr) | setv;
        if (acc && bus_we) begin
            case (reg_idx)
                1: m_rise = bus_wdata[N-1:0];
                2: m_fall = bus_wdata[N-1:0];
                4: m_mask = bus_wdata[N-1:0];
`ifdef GPIO_IRQ_LEVEL_EN
                5: m_level = bus_wdata[N-1:0];
`endif
                default: ;
            endcase
        end
        m_irq   = any;
        m_ack   = acc;
        m_prev  = gpio_read;
        m_armed = 1;
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rstz) model_edge();
        #1;
    endtask

    task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
        bus_addr = a; bus_wdata = d; bus_we = 1'b1; bus_stb = 1'b1;
        cycle();
        bus_stb = 1'b0; bus_we = 1'b0;
        cycle();
    endtask

    task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
        bus_addr = a; bus_we = 1'b0; bus_stb = 1'b1;
        cycle();
        d = bus_rdata;
        bus_stb = 1'b0;
        cycle();
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        rstz = 1'b0; gpio_read = 16'hFFFF; bus_addr = '0; bus_wdata = '0;
        bus_we = 1'b0; bus_stb = 1'b0;
        model_reset();
        #1;
        repeat (3) cycle();
        tests++;
        if (bus_ack !== 1'b0 || irq !== 1'b0 || bus_rdata !== 32'h0) begin
            fails++;
            $display("FAIL reset_outputs: ack=%b irq=%b rdata=%h, want 0/0/0", bus_ack, irq, bus_rdata);
        end
        rstz = 1'b1;
        bus_write(5'h04, 32'h0000FFFF);
        repeat (3) cycle();
        bus_read(5'h0C, rd);
        tests++;
        if (rd !== 32'h0) begin fails++; $display("FAIL reset_no_spurious_pending: got %h want 0", rd); end
        tests++;
        if (irq !== 1'b0) begin fails++; $display("FAIL reset_irq_quiet: got %b want 0", irq); end
        bus_read(5'h10, rd);
        tests++;
        if (rd !== 32'h0000FFFF) begin fails++; $display("FAIL reset_mask: got %h want 0000ffff", rd); end
        bus_read(5'h18, rd);
        tests++;
        if (rd !== 32'h0) begin fails++; $display("FAIL unmapped_0x18: got %h want 0", rd); end
    endtask

    task automatic test_rise_latency();
        logic [31:0] rd;
        bus_write(5'h04, 32'h1);
        gpio_read = '0;
        repeat (2) cycle();
        bus_write(5'h0C, 32'hFFFF);
        bus_write(5'h10, 32'hFFFE);
        repeat (2) cycle();
        gpio_read[0] = 1'b1;
        cycle();
        tests++;
        if (irq !== 1'b0) begin fails++; $display("FAIL rise_irq_t1: got %b want 0", irq); end
        cycle();
        tests++;
        if (irq !== 1'b1) begin fails++; $display("FAIL rise_irq_t2: got %b want 1", irq); end
        bus_read(5'h0C, rd);
        tests++;
        if (rd !== 32'h1) begin fails++; $display("FAIL rise_pending: got %h want 1", rd); end
        bus_write(5'h0C, 32'h1);
        gpio_read[0] = 1'b0;
        repeat (3) cycle();
        bus_read(5'h0C, rd);
        tests++;
        if (rd !== 32'h0) begin fails++; $display("FAIL rise_no_fall_set: got %h want 0", rd); end
    endtask

    task automatic test_fall_w1c();
        logic [31:0] rd;
        bus_write(5'h08, 32'h80);
        bus_write(5'h10, 32'hFF7F);
        gpio_read[7] = 1'b1;
        repeat (2) cycle();
        gpio_read[7] = 1'b0;
        repeat (2) cycle();
        tests++;
        if (irq !== 1'b1) begin fails++; $display("FAIL fall_irq: got %b want 1", irq); end
        bus_addr = 5'h0C; bus_wdata = 32'h80; bus_we = 1'b1; bus_stb = 1'b1;
        cycle();
        tests++;
        if (irq !== 1'b1) begin fails++; $display("FAIL fall_irq_at_clear_edge: got %b want 1", irq); end
        bus_stb = 1'b0; bus_we = 1'b0;
        cycle();
        tests++;
        if (irq !== 1'b0) begin fails++; $display("FAIL fall_irq_after_clear: got %b want 0", irq); end
        bus_read(5'h0C, rd);
        tests++;
        if (rd !== 32'h0) begin fails++; $display("FAIL fall_pending_cleared: got %h want 0", rd); end
    endtask

    task automatic test_w1c_collision();
        logic [31:0] rd;
        bus_write(5'h04, 32'h4);
        bus_write(5'h08, 32'h0);
        bus_write(5'h10, 32'hFFFB);
        gpio_read[2] = 1'b1;
        repeat (2) cycle();
        gpio_read[2] = 1'b0;
        cycle();
        gpio_read[2] = 1'b1;
        bus_addr = 5'h0C; bus_wdata = 32'h4; bus_we = 1'b1; bus_stb = 1'b1;
        cycle();
        bus_stb = 1'b0; bus_we = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            tests++;
            if (irq !== 1'b1) begin fails++; $display("FAIL collision_irq[%0d]: got %b want 1", k, irq); end
        end
        bus_read(5'h0C, rd);
        tests++;
        if (rd !== 32'h4) begin fails++; $display("FAIL collision_pending: got %h want 4", rd); end
        bus_write(5'h0C, 32'hFFFF);
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_d;
        gpio_read = 16'hA5C3;
        bus_write(5'h10, 32'h1234);
        bus_we = 1'b0; bus_addr = 5'h00; bus_stb = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cycle();
            tests++;
            if (bus_ack !== ((k % 2) == 0)) begin
                fails++; $display("FAIL b2b_ack[%0d]: got %b want %b", k, bus_ack, (k % 2) == 0);
            end
            if (bus_ack) begin
                exp_d = (bus_addr == 5'h00) ? 32'hA5C3 : 32'h1234;
                tests++;
                if (bus_rdata !== exp_d) begin
                    fails++; $display("FAIL b2b_rdata[%0d]: got %h want %h", k, bus_rdata, exp_d);
                end
                bus_addr = (bus_addr == 5'h00) ? 5'h10 : 5'h00;
            end
        end
        bus_stb = 1'b0;
        cycle();
        tests++;
        if (bus_ack !== 1'b0) begin fails++; $display("FAIL b2b_ack_drop: got %b want 0", bus_ack); end
        gpio_read = '0;
        bus_write(5'h0C, 32'hFFFF);
        cycle();
    endtask

    task automatic test_level();
        logic [31:0] rd;
`ifdef GPIO_IRQ_LEVEL_EN
        bus_write(5'h14, 32'h1);
        bus_write(5'h04, 32'h1);
        gpio_read[0] = 1'b1;
        repeat (2) cycle();
        bus_write(5'h0C, 32'h1);
        bus_read(5'h0C, rd);
        tests++;
        if (rd[0] !== 1'b1) begin fails++; $display("FAIL level_reassert: got %h want bit0=1", rd); end
        gpio_read[0] = 1'b0;
        cycle();
        bus_write(5'h0C, 32'h1);
        bus_read(5'h0C, rd);
        tests++;
        if (rd[0] !== 1'b0) begin fails++; $display("FAIL level_release: got %h want bit0=0", rd); end
        bus_write(5'h14, 32'h0);
`else
        bus_write(5'h14, 32'hFFFF);
        bus_read(5'h14, rd);
        tests++;
        if (rd !== 32'h0) begin fails++; $display("FAIL level_unmapped: got %h want 0", rd); end
`endif
    endtask

    task automatic test_random();
        logic [N-1:0] one;
        one = 1;
        bus_stb = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 2) == 0)
                gpio_read = gpio_read ^ (one << $urandom_range(0, N - 1));
            if (bus_ack || !bus_stb) begin
                bus_stb = ($urandom_range(0, 1) == 1);
                bus_we  = $urandom_range(0, 1);
                bus_addr = 5'($urandom_range(0, 31));
                bus_wdata = $urandom;
            end
            if (c == 300) begin
                rstz = 1'b0;
                model_reset();
                #1;
                tests++;
                if (bus_ack !== 1'b0 || irq !== 1'b0 || bus_rdata !== 32'h0) begin
                    fails++;
                    $display("FAIL rand_async_reset: ack=%b irq=%b rdata=%h", bus_ack, irq, bus_rdata);
                end
                bus_stb = 1'b0;
                cycle();
                rstz = 1'b1;
            end
            cycle();
            tests++;
            if (irq !== m_irq || bus_ack !== m_ack || (m_ack && bus_rdata !== m_rdata)) begin
                fails++;
                $display("FAIL rand_cycle[%0d]: irq=%b ack=%b rdata=%h want irq=%b ack=%b rdata=%h",
                         c, irq, bus_ack, bus_rdata, m_irq, m_ack, m_rdata);
            end
        end
        bus_stb = 1'b0;
        cycle();
    endtask

    initial begin
        test_reset();
        test_rise_latency();
        test_fall_w1c();
        test_w1c_collision();
        test_back_to_back();
        test_level();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/gpio_irq_ctrl.md
Name: gpio_irq_ctrl

Overview:
- Interrupt controller and register front-end for the debounced GPIO group.
- Takes the stable per-pin levels from the GPIO input debouncer and detects rising and falling edges on each pin.
- Latches detected edges into a pending register and raises a single maskable interrupt line to the core.
- Software reads, configures and clears it through a simple strobe/ack register port on the peripheral bus.

Parameters:
- N, 16, number of GPIO pins handled; legal range 1..32.

Ports:
- clk  input  1  system clock
- rstz  input  1  asynchronous active-low reset
- gpio_read  input  N  debounced pin levels; already synchronous to clk
- bus_addr  input  5  byte address; bits [1:0] ignored
- bus_wdata  input  32  write data
- bus_we  input  1  1 = write, 0 = read
- bus_stb  input  1  transaction request; held high until bus_ack
- bus_rdata  output  32  read data; valid while bus_ack = 1
- bus_ack  output  1  one-cycle transaction acknowledge
- irq  output  1  registered interrupt request, level-high

Behaviour:
- Clock and reset: single clock clk. Reset rstz is asynchronous and active-low. All flops clear immediately on rstz = 0.
- Reset values: bus_ack = 0, bus_rdata = 0, irq = 0. RISE_EN, FALL_EN, PENDING and prev are all 0. MASK is all 1s (every pin masked). armed = 0.
- Register map (word offsets). Bits [31:N] read as 0 and ignore writes.
  - 0x00 DATA: read-only, current gpio_read.
  - 0x04 RISE_EN: R/W.
  - 0x08 FALL_EN: R/W.
  - 0x0C PENDING: read; write-1-to-clear.
  - 0x10 MASK: R/W, 1 = masked.
  - Unmapped addresses: read 0, writes ignored.
- Edge detection:
  - prev <= gpio_read every cycle.
  - armed <= 1 one cycle after reset release.
  - While armed = 0, no edges are detected. This prevents spurious edges from pins that are already high at reset.
  - rise[i] = armed & gpio_read[i] & ~prev[i]; fall[i] = armed & ~gpio_read[i] & prev[i].
  - set[i] = (rise[i] & RISE_EN[i]) | (fall[i] & FALL_EN[i]).
- Pending update: PENDING <= (PENDING & ~clr) | set. clr is bus_wdata[N-1:0] on an accepted write to 0x0C, otherwise 0.
  - If set and clear hit the same bit in the same cycle, set wins and the bit stays 1.
  - Enables gate detection only. Clearing RISE_EN or FALL_EN never clears bits already pending.
- Interrupt: irq <= |(PENDING & ~MASK), registered.
  - Latency: gpio_read changes in cycle t; PENDING bit is 1 from t+1; irq is 1 from t+2.
  - Unmasking an already-pending bit raises irq one cycle after the MASK write edge.
- Bus handshake:
  - A transaction is accepted in any cycle with bus_stb = 1 and bus_ack = 0.
  - On the accept edge, a write updates its register and a read captures bus_rdata from register state before that edge.
  - bus_ack = 1 for exactly the next cycle, then returns to 0.
  - The requester drops bus_stb or presents a new request after seeing bus_ack. Maximum throughput is one transaction per 2 cycles.
  - bus_stb low with bus_ack high: ack still drops next cycle.
- Reset mid-transaction: the pending ack is lost. The requester reissues the transaction after reset.

Optional Feature:
- Macro: GPIO_IRQ_LEVEL_EN.
- When defined:
  - Adds register 0x14 LEVEL (R/W, reset 0).
  - Pins with LEVEL[i] = 1 are level-sensitive: set[i] = gpio_read[i] & RISE_EN[i] every cycle, with the armed gate still applied.
  - Their pending bit reasserts after W1C for as long as the level persists.
  - Edge rules are unchanged for LEVEL[i] = 0.
- When undefined: 0x14 is unmapped (reads 0), and all pins are edge-only.

Test Plan:
- Reset with gpio_read = 0xFFFF and RISE_EN written to 0xFFFF afterwards -> PENDING reads 0x0000 and irq stays 0.
- RISE_EN = 0x0001, MASK = 0xFFFE, gpio_read[0] steps 0→1 in cycle t -> PENDING = 0x0001 at t+1, irq = 1 at t+2. Then gpio_read[0] steps 1→0 -> no new set.
- FALL_EN = 0x0080, bit 7 falls, then write 0x0080 to 0x0C -> PENDING = 0x0000 and irq drops one cycle after the PENDING update.
- W1C of 0x0004 in the same cycle as a new enabled rising edge on bit 2 -> PENDING[2] remains 1 and irq stays high.
- Back-to-back bus_stb held high across reads of 0x00 and 0x10 -> bus_ack pulses every other cycle. After reset, MASK read returns 0x0000FFFF and unmapped 0x18 returns 0.
- Under GPIO_IRQ_LEVEL_EN: LEVEL = 0x0001, RISE_EN = 0x0001, gpio_read[0] held high, W1C bit 0 -> PENDING[0] reads 1 again on the next read. After gpio_read[0] goes low and W1C -> reads 0.
